xbar_route_scheduler: RTL and testbench

Sequences the unstructured-sparsity crossbar. It converts per-column routing configs (which input row feeds each output column) into the N_IN x N_OUT grid of switch ctrl bits, and holds each config for a programmed number of data beats. A one-deep shadow buffer lets the next tile's config be accepted while the current one is in use, giving zero-bubble tile switching. It sits between the sparse-index fetch logic (upstream, valid/ready) and the crossbar_switch grid (downstream).

---
 rtl/xbar_sched_pkg.sv | 16 +
 rtl/xbar_route_decode.sv | 28 ++
 rtl/xbar_route_scheduler.sv | 135 +++++++++++++
 tb/tb_xbar_route_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_sched_pkg.sv
// Shared types and helpers for the crossbar route scheduler.
package xbar_sched_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } sched_state_e;

    // Flat position of switch (row, col) inside the ctrl grid.
    function automatic int unsigned grid_idx(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned n_out);
        return row * n_out + col;
    endfunction

endpackage

// File: rtl/xbar_route_decode.sv
// Turns per-column row selects into the one-hot-per-column switch grid.
module xbar_route_decode
    import xbar_sched_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int IW    = 2
) (
    input  logic [N_OUT*IW-1:0]   sel_i,
    input  logic [N_OUT-1:0]      en_i,
    output logic [N_IN*N_OUT-1:0] grid_o,
    output logic                  bad_sel_o
);

    logic [N_OUT-1:0] bad_col;

    for (genvar j = 0; j < N_OUT; j++) begin : g_col
        // An enabled column whose select names a row that does not exist.
        assign bad_col[j] = en_i[j] && (32'(sel_i[j*IW +: IW]) >= 32'(N_IN));
        for (genvar i = 0; i < N_IN; i++) begin : g_row
            assign grid_o[grid_idx(i, j, N_OUT)] =
                en_i[j] && (sel_i[j*IW +: IW] == IW'(i));
        end
    end

    assign bad_sel_o = |bad_col;

endmodule

// File: rtl/xbar_route_scheduler.sv
// Holds decoded crossbar configs for a programmed number of beats, with a
// one-deep shadow so the next tile can be queued while the current one runs.
module xbar_route_scheduler
    import xbar_sched_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int IW    = 2,
    parameter int LW    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [N_OUT*IW-1:0]   cfg_sel,
    input  logic [N_OUT-1:0]      cfg_en,
    input  logic [LW-1:0]         cfg_len,
    input  logic                  beat_valid,
    output logic [N_IN*N_OUT-1:0] ctrl_out,
    output logic                  ctrl_valid,
    output logic                  tile_done,
    output logic                  err_sel
);

    localparam int GW = N_IN * N_OUT;

    sched_state_e  state_q, state_d;
    logic [GW-1:0] grid_q, grid_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          sh_full_q, sh_full_d;
    logic [GW-1:0] sh_grid_q, sh_grid_d;
    logic [LW-1:0] sh_len_q, sh_len_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [GW-1:0] dec_grid;
    logic          dec_bad;
    logic          accept;
    logic          last_beat;

    xbar_route_decode #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .IW    (IW)
    ) u_decode (
        .sel_i     (cfg_sel),
        .en_i      (cfg_en),
        .grid_o    (dec_grid),
        .bad_sel_o (dec_bad)
    );

    assign cfg_ready  = !sh_full_q;
    assign accept     = cfg_valid && cfg_ready;
    assign last_beat  = (state_q == ACTIVE) && beat_valid && (cnt_q == '0);

    assign ctrl_out   = grid_q;
    assign ctrl_valid = (state_q == ACTIVE);
    assign tile_done  = done_q;
    assign err_sel    = err_q;

    // Next-state: tile sequencing, shadow fill/drain and beat counting.
    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        cnt_d     = cnt_q;
        sh_full_d = sh_full_q;
        sh_grid_d = sh_grid_q;
        sh_len_d  = sh_len_q;
        done_d    = 1'b0;
        err_d     = err_q || (accept && dec_bad);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    grid_d  = dec_grid;
                    cnt_d   = cfg_len;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (beat_valid && (cnt_q != '0)) begin
                    cnt_d = cnt_q - LW'(1);
                end
                if (last_beat) begin
                    done_d = 1'b1;
                    // Shadow cannot be full and accept at once, so a same-cycle
                    // accept goes straight to active without touching the shadow.
                    if (sh_full_q) begin
                        grid_d    = sh_grid_q;
                        cnt_d     = sh_len_q;
                        sh_full_d = 1'b0;
                    end else if (accept) begin
                        grid_d = dec_grid;
                        cnt_d  = cfg_len;
                    end else begin
                        grid_d  = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    sh_full_d = 1'b1;
                    sh_grid_d = dec_grid;
                    sh_len_d  = cfg_len;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset that drops both configs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grid_q    <= '0;
            cnt_q     <= '0;
            sh_full_q <= 1'b0;
            sh_grid_q <= '0;
            sh_len_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            cnt_q     <= cnt_d;
            sh_full_q <= sh_full_d;
            sh_grid_q <= sh_grid_d;
            sh_len_q  <= sh_len_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_xbar_route_scheduler.sv
// Directed bench for xbar_route_scheduler; a second N_IN=3 instance covers
// out-of-range selects.
module tb_xbar_route_scheduler;

    logic        clk;
    logic        reset;
    logic        cfg_valid;
    logic [7:0]  cfg_sel;
    logic [3:0]  cfg_en;
    logic [3:0]  cfg_len;
    logic        beat_valid;

    logic        cfg_ready;
    logic [15:0] ctrl_out;
    logic        ctrl_valid;
    logic        tile_done;
    logic        err_sel;

    logic        cfg_ready3;
    logic [11:0] ctrl_out3;
    logic        ctrl_valid3;
    logic        tile_done3;
    logic        err_sel3;

    int unsigned n_checks;
    int unsigned n_errors;

    xbar_route_scheduler #(
        .N_IN  (4),
        .N_OUT (4),
        .IW    (2),
        .LW    (4)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_sel    (cfg_sel),
        .cfg_en     (cfg_en),
        .cfg_len    (cfg_len),
        .beat_valid (beat_valid),
        .ctrl_out   (ctrl_out),
        .ctrl_valid (ctrl_valid),
        .tile_done  (tile_done),
        .err_sel    (err_sel)
    );

    xbar_route_scheduler #(
        .N_IN  (3),
        .N_OUT (4),
        .IW    (2),
        .LW    (4)
    ) u_dut3 (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready3),
        .cfg_sel    (cfg_sel),
        .cfg_en     (cfg_en),
        .cfg_len    (cfg_len),
        .beat_valid (beat_valid),
        .ctrl_out   (ctrl_out3),
        .ctrl_valid (ctrl_valid3),
        .tile_done  (tile_done3),
        .err_sel    (err_sel3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic offer(input logic [7:0] sel, input logic [3:0] en, input logic [3:0] len);
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_en    = en;
        cfg_len   = len;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        cfg_valid  = 1'b0;
        beat_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        cfg_valid  = 1'b1;          // offered during reset: must be dropped
        cfg_sel    = 8'hE4;
        cfg_en     = 4'hF;
        cfg_len    = 4'd0;
        beat_valid = 1'b0;
        step();
        step();
        cfg_valid = 1'b0;
        reset     = 1'b0;
        step();

        // Reset state and idle with beat_valid toggling
        check("rst_ctrl_out", 32'(ctrl_out), 32'h0);
        check("rst_ctrl_valid", 32'(ctrl_valid), 32'h0);
        check("rst_tile_done", 32'(tile_done), 32'h0);
        check("rst_err_sel", 32'(err_sel), 32'h0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            beat_valid = i[0];
            step();
            check("idle_valid", 32'(ctrl_valid), 32'h0);
            check("idle_done", 32'(tile_done), 32'h0);
        end
        beat_valid = 1'b0;

        // Single tile: col j -> row j, 3 beats; bits 0,5,10,15
        offer({2'd3, 2'd2, 2'd1, 2'd0}, 4'hF, 4'd2);
        step();
        cfg_valid = 1'b0;
        check("t1_ctrl_out", 32'(ctrl_out), 32'h8421);
        check("t1_valid", 32'(ctrl_valid), 32'h1);
        step();                       // a cycle without beat must not count
        check("t1_hold", 32'(ctrl_out), 32'h8421);
        beat_valid = 1'b1;
        step();
        check("t1_b1_done", 32'(tile_done), 32'h0);
        step();
        check("t1_b2_done", 32'(tile_done), 32'h0);
        check("t1_b2_ctrl", 32'(ctrl_out), 32'h8421);
        step();
        beat_valid = 1'b0;
        check("t1_done", 32'(tile_done), 32'h1);
        check("t1_end_valid", 32'(ctrl_valid), 32'h0);
        check("t1_end_ctrl", 32'(ctrl_out), 32'h0);
        step();
        check("t1_done_pulse", 32'(tile_done), 32'h0);

        // Back-to-back through the shadow: A len=1, B all sel 0 len=1
        offer({2'd3, 2'd2, 2'd1, 2'd0}, 4'hF, 4'd1);
        step();
        check("bb_a_ctrl", 32'(ctrl_out), 32'h8421);
        offer(8'h00, 4'hF, 4'd1);
        step();
        cfg_valid = 1'b0;
        check("bb_sh_ready", 32'(cfg_ready), 32'h0);
        check("bb_a_hold", 32'(ctrl_out), 32'h8421);
        beat_valid = 1'b1;
        step();
        check("bb_a_b1_ctrl", 32'(ctrl_out), 32'h8421);
        check("bb_a_b1_ready", 32'(cfg_ready), 32'h0);
        step();
        check("bb_b_ctrl", 32'(ctrl_out), 32'h000F);
        check("bb_b_valid", 32'(ctrl_valid), 32'h1);
        check("bb_a_done", 32'(tile_done), 32'h1);
        check("bb_b_ready", 32'(cfg_ready), 32'h1);
        step();
        check("bb_b_b1_done", 32'(tile_done), 32'h0);
        step();
        beat_valid = 1'b0;
        check("bb_b_done", 32'(tile_done), 32'h1);
        check("bb_end_valid", 32'(ctrl_valid), 32'h0);

        // Bypass on the last beat, next tile is broadcast with disabled columns
        offer({2'd3, 2'd2, 2'd1, 2'd0}, 4'hF, 4'd0);
        step();
        offer(8'h55, 4'b0101, 4'd0);
        beat_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("byp_ctrl", 32'(ctrl_out), 32'h0050);
        check("byp_valid", 32'(ctrl_valid), 32'h1);
        check("byp_done", 32'(tile_done), 32'h1);
        check("byp_ready", 32'(cfg_ready), 32'h1);
        check("byp_err", 32'(err_sel), 32'h0);
        step();
        beat_valid = 1'b0;
        check("byp_end_done", 32'(tile_done), 32'h1);
        check("byp_end_valid", 32'(ctrl_valid), 32'h0);

        // Longest tile: len all ones gives 16 beats
        offer(8'hE4, 4'hF, 4'hF);
        step();
        cfg_valid  = 1'b0;
        beat_valid = 1'b1;
        for (int b = 0; b < 15; b++) begin
            step();
            check("long_mid_done", 32'(tile_done), 32'h0);
            check("long_mid_valid", 32'(ctrl_valid), 32'h1);
        end
        step();
        beat_valid = 1'b0;
        check("long_done", 32'(tile_done), 32'h1);
        check("long_end_valid", 32'(ctrl_valid), 32'h0);

        // Bad select on the 3-row instance, column 0 selects row 3
        do_reset();
        check("bad_rst_err", 32'(err_sel3), 32'h0);
        offer(8'h03, 4'b0001, 4'd0);
        step();
        cfg_valid = 1'b0;
        check("bad_ctrl3", 32'(ctrl_out3), 32'h000);
        check("bad_valid3", 32'(ctrl_valid3), 32'h1);
        check("bad_err3", 32'(err_sel3), 32'h1);
        check("bad_ctrl4", 32'(ctrl_out), 32'h1000);
        check("bad_err4", 32'(err_sel), 32'h0);
        beat_valid = 1'b1;
        repeat (4) step();
        beat_valid = 1'b0;
        check("bad_err3_held", 32'(err_sel3), 32'h1);
        do_reset();
        check("bad_err3_clr", 32'(err_sel3), 32'h0);

        // Reset mid-tile with the shadow full
        offer(8'hE4, 4'hF, 4'd5);
        step();
        offer(8'h00, 4'hF, 4'd1);
        step();
        cfg_valid = 1'b0;
        check("mr_sh_full", 32'(cfg_ready), 32'h0);
        beat_valid = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mr_ctrl", 32'(ctrl_out), 32'h0);
        check("mr_valid", 32'(ctrl_valid), 32'h0);
        check("mr_done", 32'(tile_done), 32'h0);
        check("mr_ready", 32'(cfg_ready), 32'h1);
        for (int k = 0; k < 6; k++) begin
            step();
            check("mr_after_done", 32'(tile_done), 32'h0);
            check("mr_after_valid", 32'(ctrl_valid), 32'h0);
        end
        beat_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
